// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard/stall control bundle: ID/EX hazard inputs and IF/ID, ID/EX, PC control outputs.
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  en;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  id_mc_op;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  IFID_write;
    logic                  pc_hold;
    logic                  idex_bubble;
    logic                  idex_hold;
    logic                  ifid_flush;
    logic                  mc_busy;
    logic [15:0]           stall_cnt;

    modport master (
        output en, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_mc_op,
               ex_mem_read, ex_rd, ex_branch_taken,
        input  IFID_write, pc_hold, idex_bubble, idex_hold, ifid_flush,
               mc_busy, stall_cnt
    );

    modport slave (
        input  en, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_mc_op,
               ex_mem_read, ex_rd, ex_branch_taken,
        output IFID_write, pc_hold, idex_bubble, idex_hold, ifid_flush,
               mc_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / multi-cycle-op stall controller for an in-order pipeline.
// Optional stall statistic counter enabled by macro HAZARD_STATS_EN.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT     = 4
) (
    input logic                clk,
    input logic                arst,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic {RUN = 1'b0, MC_STALL = 1'b1} state_e;

    localparam logic [3:0] MC_INIT   = 4'(MC_LAT - 1);
    localparam bit         MC_ENABLE = (MC_LAT > 1);

    state_e                state_q, state_d;
    logic [3:0]            mc_cnt_q, mc_cnt_d;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  lu;
    logic                  ifid_write;
    logic                  pc_hold;
    logic                  idex_bubble;
    logic                  idex_hold;
    logic                  ifid_flush;
    logic                  mc_busy;

    assign ex_rd = hz.ex_rd;
    assign lu    = hz.ex_mem_read && (ex_rd != '0) &&
                   ((hz.id_uses_rs1 && (hz.id_rs1 == ex_rd)) ||
                    (hz.id_uses_rs2 && (hz.id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        if (hz.en) begin
            case (state_q)
                RUN: begin
                    // Branch flush and load-use stall both pre-empt issuing the multi-cycle op.
                    if (MC_ENABLE && hz.id_mc_op && !hz.ex_branch_taken && !lu) begin
                        state_d  = MC_STALL;
                        mc_cnt_d = MC_INIT;
                    end
                end
                MC_STALL: begin
                    mc_cnt_d = mc_cnt_q - 4'd1;
                    if (mc_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        ifid_write  = 1'b0;
        pc_hold     = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        ifid_flush  = 1'b0;
        mc_busy     = 1'b0;
        // Reset gates the outputs combinationally, independent of the other inputs.
        if (!arst) begin
            case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu) begin
                        ifid_write  = 1'b1;
                        pc_hold     = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                MC_STALL: begin
                    ifid_write = 1'b1;
                    pc_hold    = 1'b1;
                    idex_hold  = 1'b1;
                    mc_busy    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.IFID_write  = ifid_write;
    assign hz.pc_hold     = pc_hold;
    assign hz.idex_bubble = idex_bubble;
    assign hz.idex_hold   = idex_hold;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.mc_busy     = mc_busy;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.en && ifid_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  REG_ADDR_W, 5, register-index width.
  MC_LAT, 4, multi-cycle EX op latency in cycles; legal range 1..16.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk, in, 1, single clock.
  arst, in, 1, reset, asynchronous, active-high.
  en, in, 1, global pipeline enable.
  id_rs1, in, REG_ADDR_W, ID-stage source 1.
  id_rs2, in, REG_ADDR_W, ID-stage source 2.
  id_uses_rs1, in, 1, ID instruction reads rs1.
  id_uses_rs2, in, 1, ID instruction reads rs2.
  id_mc_op, in, 1, ID instruction is a multi-cycle EX op.
  ex_mem_read, in, 1, EX instruction is a load.
  ex_rd, in, REG_ADDR_W, EX destination.
  ex_branch_taken, in, 1, EX resolved taken branch/jump.
  IFID_write, out, 1, 1 = IF/ID register holds, 0 = loads.
  pc_hold, out, 1, 1 = PC holds.
  idex_bubble, out, 1, 1 = ID/EX loads a NOP.
  idex_hold, out, 1, 1 = ID/EX holds its contents.
  ifid_flush, out, 1, 1 = IF/ID loads a NOP.
  mc_busy, out, 1, 1 while in MC_STALL.
  stall_cnt, out, 16, stall-cycle statistic.

Function
REQ-003 The FSM SHALL have two states: RUN and MC_STALL; a 4-bit down-counter mc_cnt SHALL track MC_STALL length.
REQ-004 The load-use hazard lu SHALL be: ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-005 In RUN, the outputs SHALL be combinational, same cycle, in this priority: ex_branch_taken -> ifid_flush=1, idex_bubble=1; else lu -> IFID_write=1, pc_hold=1, idex_bubble=1; else all outputs 0.
REQ-006 In RUN with en=1, id_mc_op=1, ex_branch_taken=0, lu=0 and MC_LAT>1, the next state SHALL be MC_STALL with mc_cnt=MC_LAT-1.
REQ-007 In MC_STALL, the block SHALL drive IFID_write=1, pc_hold=1, idex_hold=1, mc_busy=1, idex_bubble=0 and ifid_flush=0, and SHALL ignore ex_branch_taken and lu.
REQ-008 In MC_STALL with en=1, mc_cnt SHALL decrement each cycle; when mc_cnt==1, the next state SHALL be RUN, so the total hold is MC_LAT-1 cycles.
REQ-009 With MC_LAT=1, the block SHALL never enter MC_STALL.
REQ-010 With en=0, the state, mc_cnt and stall_cnt SHALL hold; the outputs SHALL still follow REQ-005/REQ-007 for the current state.
REQ-011 When branch and id_mc_op coincide in RUN, flush SHALL win and MC_STALL SHALL NOT be entered.
REQ-012 When lu and id_mc_op coincide in RUN, the lu stall SHALL win and MC_STALL SHALL NOT be entered; the op re-evaluates next cycle.

Reset
REQ-013 While arst=1, the state SHALL be RUN, mc_cnt=0, stall_cnt=0, and all outputs SHALL be forced to 0, regardless of the other inputs.
REQ-014 Assertion of arst mid-MC_STALL SHALL abort to RUN immediately, without waiting for a clock edge.
REQ-015 After arst deasserts, the first rising clk edge SHALL be a normal RUN cycle.

Configuration
REQ-016 Macro HAZARD_STATS_EN: when defined, stall_cnt SHALL increment (saturating at 16'hFFFF) on each clk edge where en=1 and IFID_write=1; when undefined, stall_cnt SHALL be constant 0 and no counter logic SHALL be built; the port SHALL exist in both cases.

Verification
REQ-017 The bench SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> IFID_write=1, pc_hold=1, idex_bubble=1 same cycle; 0 when ex_rd=0.
REQ-018 The bench SHALL cover multi-cycle: MC_LAT=4, id_mc_op pulse in RUN -> mc_busy=1, IFID_write=1, idex_hold=1 for exactly 3 cycles, then RUN.
REQ-019 The bench SHALL cover priority: ex_branch_taken=1 with lu=1 and id_mc_op=1 -> ifid_flush=1, idex_bubble=1, IFID_write=0, no MC_STALL entry.
REQ-020 The bench SHALL cover en gating: en=0 for 2 cycles mid-MC_STALL (MC_LAT=4) -> hold extends to 5 cycles total; stall_cnt frozen during en=0.
REQ-021 The bench SHALL cover reset: arst pulse during cycle 2 of MC_STALL -> all outputs 0 asynchronously, state RUN, stall_cnt=0.
REQ-022 The bench SHALL cover stats: with HAZARD_STATS_EN, 3 lu cycles plus one MC_LAT=4 op -> stall_cnt=6; without the macro -> stall_cnt=0.
